// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game engine: cell and result codes,
// FSM state encoding and the 7-segment glyphs (active-high, bit0=a .. bit6=g).
// No logic, no latency, no flow control.
package ttt_pkg;

  // Cell occupancy codes, two bits per board cell
  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;

  // Game result codes
  localparam logic [1:0] RES_PLAY = 2'b00;
  localparam logic [1:0] RES_XWIN = 2'b01;
  localparam logic [1:0] RES_OWIN = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_PLACE,
    ST_CHECK,
    ST_DONE
  } state_e;

  // 7-segment glyphs
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_R     = 7'b1010000;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Digit shown for a player: 0 = X (P1), 1 = O (P2)
  function automatic logic [6:0] player_glyph(input logic o_player);
    return o_player ? SEG_2 : SEG_1;
  endfunction

endpackage

// File: rtl/ttt_game_engine_if.sv
// Keypad-in / game-state-out bundle between keypad decoder, engine and renderer.
// master = keypad/host side (drives keys, observes state); slave = engine.
// Key strobe is edge-triggered; there is no backpressure on this bundle.
interface ttt_game_engine_if #(
  parameter int N  = 3,
  parameter int KW = 7
) ();
  logic               key_valid;
  logic [KW-1:0]      key_data;
  logic [2*N*N-1:0]   board;
  logic               turn_o;
  logic [1:0]         result;
  logic [6:0]         move_count;
  logic               reject;
  logic               busy;

  modport master (
    output key_valid, key_data,
    input  board, turn_o, result, move_count, reject, busy
  );

  modport slave (
    input  key_valid, key_data,
    output board, turn_o, result, move_count, reject, busy
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Scanned 8-digit 7-segment driver with per-frame blink of the glyph set.
// Latency: a glyph change appears at the next scan step of its digit.
// Backpressure: none; free-running counters whenever out of reset.
// Ports: clk/rst_n; enable (0 blanks all digits), blink_en, glyphs[7:0]
//        (glyphs[0] = leftmost digit); seg_txt active-high, seg_com active-low.
module seg_scan_driver
  import ttt_pkg::*;
#(
  parameter int SCAN_DIV  = 25000,
  parameter int BLINK_DIV = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            blink_en,
  input  logic [7:0][6:0] glyphs,
  output logic [6:0]      seg_txt,
  output logic [7:0]      seg_com
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    digit_q, digit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [6:0]    txt_q, txt_d;
  logic [7:0]    com_q, com_d;
  logic          scan_wrap;

  always_comb begin
    scan_wrap     = (scan_cnt_q == SW'(SCAN_DIV - 1));
    scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    digit_d       = digit_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    txt_d         = txt_q;
    com_d         = com_q;
    if (scan_wrap) begin
      // Present the current digit, then step to the next (3-bit wrap 7->0)
      digit_d = digit_q + 3'd1;
      com_d   = ~(8'h80 >> digit_q);
      txt_d   = (blink_en && blink_phase_q) ? SEG_BLANK : glyphs[digit_q];
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      txt_q         <= SEG_BLANK;
      com_q         <= 8'hFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      txt_q         <= txt_d;
      com_q         <= com_d;
    end
  end

  assign seg_txt = enable ? txt_q : SEG_BLANK;
  assign seg_com = enable ? com_q : 8'hFF;

endmodule

// File: rtl/ttt_game_engine.sv
// N x N, K-in-a-row game engine: validates keypad moves, places marks, checks lines.
// Latency: PLACE 1 cycle + CHECK 8*(K-1) cycles; result/turn update on CHECK exit.
// Backpressure: key edges during PLACE/CHECK/DONE are dropped (busy high in PLACE/CHECK).
// Ports: clk, rst_n, is_main (freeze), new_game (clear), gif (slave: keys in,
//        board/turn_o/result/move_count/reject/busy out), seg_txt/seg_com display.
module ttt_game_engine
  import ttt_pkg::*;
#(
  parameter int N         = 3,
  parameter int K         = 3,
  parameter int SCAN_DIV  = 25000,
  parameter int BLINK_DIV = 256,
  parameter int KW        = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 is_main,
  input  logic                 new_game,
  ttt_game_engine_if.slave     gif,
  output logic [6:0]           seg_txt,
  output logic [7:0]           seg_com
);
  localparam int NN = N * N;

  state_e           state_q, state_d;
  logic [2*NN-1:0]  board_q, board_d;
  logic             turn_q, turn_d;
  logic [1:0]       result_q, result_d;
  logic [6:0]       mc_q, mc_d;
  logic             reject_q, reject_d;
  logic             key_valid_q, key_valid_d;
  logic [5:0]       cell_q, cell_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  // Line-checker walk: direction, forward/backward phase, step distance,
  // run length so far, whether the run is still unbroken, win seen so far
  logic [1:0]       dir_q, dir_d;
  logic             bwd_q, bwd_d;
  logic [2:0]       dist_q, dist_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             alive_q, alive_d;
  logic             win_q, win_d;

  logic             key_edge, key_ok;
  int               key_idx, nr, nc, s;
  logic             in_bounds, hit, phase_end, dir_end, dir_win, last_step, win_now;
  logic [3:0]       cnt_step;
  logic [1:0]       my_mark;

  logic [7:0][6:0]  glyphs;
  logic             blink_en, disp_en;

  function automatic logic [1:0] cell_at(input logic [2*NN-1:0] b, input int idx);
    logic [1:0] v;
    v = EMPTY;
    for (int i = 0; i < NN; i++) begin
      if (i == idx) v = b[2*i +: 2];
    end
    return v;
  endfunction

  always_comb begin
    // Key qualification
    key_valid_d = gif.key_valid;
    key_edge    = gif.key_valid & ~key_valid_q;
    key_idx     = int'(gif.key_data) - 1;
    key_ok      = (gif.key_data != '0) && (int'(gif.key_data) <= NN) &&
                  (cell_at(board_q, key_idx) == EMPTY);
    my_mark     = turn_q ? MARK_O : MARK_X;

    // Neighbour examined this cycle; anti-diagonal runs forward down-left
    s  = bwd_q ? -int'(dist_q) : int'(dist_q);
    nr = int'(row_q);
    nc = int'(col_q);
    case (dir_q)
      2'd0:    nc = nc + s;
      2'd1:    nr = nr + s;
      2'd2:    begin nr = nr + s; nc = nc + s; end
      default: begin nr = nr + s; nc = nc - s; end
    endcase
    in_bounds = (nr >= 0) && (nr < N) && (nc >= 0) && (nc < N);
    hit       = alive_q && in_bounds && (cell_at(board_q, nr * N + nc) == my_mark);
    cnt_step  = cnt_q + (hit ? 4'd1 : 4'd0);
    phase_end = (dist_q == 3'(K - 1));
    dir_end   = phase_end && bwd_q;
    dir_win   = dir_end && ((int'(cnt_step) + 1) >= K);
    last_step = dir_end && (dir_q == 2'd3);
    win_now   = win_q | dir_win;

    // Defaults
    state_d  = state_q;
    board_d  = board_q;
    turn_d   = turn_q;
    result_d = result_q;
    mc_d     = mc_q;
    reject_d = 1'b0;
    cell_d   = cell_q;
    row_d    = row_q;
    col_d    = col_q;
    dir_d    = dir_q;
    bwd_d    = bwd_q;
    dist_d   = dist_q;
    cnt_d    = cnt_q;
    alive_d  = alive_q;
    win_d    = win_q;

    if (is_main) begin
      // Abandon any move in flight; placed mark and count stay, turn unchanged
      state_d = ST_IDLE;
    end else if (new_game && (state_q != ST_IDLE)) begin
      board_d  = '0;
      turn_d   = 1'b0;
      result_d = RES_PLAY;
      mc_d     = '0;
      state_d  = ST_WAIT_KEY;
    end else begin
      case (state_q)
        ST_IDLE: state_d = (result_q != RES_PLAY) ? ST_DONE : ST_WAIT_KEY;
        ST_WAIT_KEY: begin
          if (key_edge) begin
            if (key_ok) begin
              cell_d  = 6'(key_idx);
              row_d   = 3'(key_idx / N);
              col_d   = 3'(key_idx % N);
              state_d = ST_PLACE;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        ST_PLACE: begin
          for (int i = 0; i < NN; i++) begin
            if (i == int'(cell_q)) board_d[2*i +: 2] = my_mark;
          end
          mc_d    = mc_q + 7'd1;
          dir_d   = 2'd0;
          bwd_d   = 1'b0;
          dist_d  = 3'd1;
          cnt_d   = '0;
          alive_d = 1'b1;
          win_d   = 1'b0;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          alive_d = hit;
          cnt_d   = cnt_step;
          if (phase_end) begin
            dist_d  = 3'd1;
            alive_d = 1'b1;
            if (bwd_q) begin
              bwd_d = 1'b0;
              dir_d = dir_q + 2'd1;
              cnt_d = '0;
              win_d = win_now;
            end else begin
              bwd_d = 1'b1;
            end
          end else begin
            dist_d = dist_q + 3'd1;
          end
          if (last_step) begin
            // A completed line wins even on the board-filling move
            if (win_now) begin
              result_d = turn_q ? RES_OWIN : RES_XWIN;
              state_d  = ST_DONE;
            end else if (mc_q == 7'(NN)) begin
              result_d = RES_DRAW;
              state_d  = ST_DONE;
            end else begin
              turn_d  = ~turn_q;
              state_d = ST_WAIT_KEY;
            end
          end
        end
        default: ;  // ST_DONE: keys ignored until new_game
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      board_q     <= '0;
      turn_q      <= 1'b0;
      result_q    <= RES_PLAY;
      mc_q        <= '0;
      reject_q    <= 1'b0;
      key_valid_q <= 1'b0;
      cell_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      dir_q       <= '0;
      bwd_q       <= 1'b0;
      dist_q      <= 3'd1;
      cnt_q       <= '0;
      alive_q     <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      turn_q      <= turn_d;
      result_q    <= result_d;
      mc_q        <= mc_d;
      reject_q    <= reject_d;
      key_valid_q <= key_valid_d;
      cell_q      <= cell_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dir_q       <= dir_d;
      bwd_q       <= bwd_d;
      dist_q      <= dist_d;
      cnt_q       <= cnt_d;
      alive_q     <= alive_d;
      win_q       <= win_d;
    end
  end

  assign gif.board      = board_q;
  assign gif.turn_o     = turn_q;
  assign gif.result     = result_q;
  assign gif.move_count = mc_q;
  assign gif.reject     = reject_q;
  assign gif.busy       = (state_q == ST_PLACE) || (state_q == ST_CHECK);

  // Display content
  always_comb begin
    for (int d = 0; d < 8; d++) glyphs[d] = SEG_BLANK;
    blink_en = 1'b0;
    disp_en  = (state_q != ST_IDLE);
    case (result_q)
      RES_PLAY: begin
        glyphs[0] = SEG_P;
        glyphs[1] = player_glyph(turn_q);
      end
      RES_XWIN: begin
        glyphs[0] = SEG_P;
        glyphs[1] = SEG_1;
        blink_en  = 1'b1;
      end
      RES_OWIN: begin
        glyphs[0] = SEG_P;
        glyphs[1] = SEG_2;
        blink_en  = 1'b1;
      end
      default: begin
        glyphs[0] = SEG_D;
        glyphs[1] = SEG_R;
        glyphs[2] = SEG_A;
      end
    endcase
  end

  seg_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) u_seg (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (disp_en),
    .blink_en (blink_en),
    .glyphs   (glyphs),
    .seg_txt  (seg_txt),
    .seg_com  (seg_com)
  );

endmodule
